// File: rtl/control_unit.sv
// Multi-cycle processor control FSM: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions.
module control_unit #(
    parameter int OP_CODE_LENGTH = 4,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [OP_CODE_LENGTH-1:0] op_code,
    input  logic                      is_alu_operation,
    input  logic                      zero_flag,
    input  logic                      mem_ready,
    output logic                      mem_req,
    output logic                      mem_write,
    output logic                      mem_addr_sel,
    output logic                      ir_load,
    output logic                      pc_increment,
    output logic                      pc_load,
    output logic                      alu_enable,
    output logic                      reg_write,
    output logic [1:0]                reg_write_sel,
    output logic                      halted,
    output logic [2:0]                state,
    output logic [COUNT_WIDTH-1:0]    retired_count
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    localparam logic [OP_CODE_LENGTH-1:0] OP_LOADI = OP_CODE_LENGTH'(4'b1000);
    localparam logic [OP_CODE_LENGTH-1:0] OP_LOAD  = OP_CODE_LENGTH'(4'b1001);
    localparam logic [OP_CODE_LENGTH-1:0] OP_STORE = OP_CODE_LENGTH'(4'b1010);
    localparam logic [OP_CODE_LENGTH-1:0] OP_JMP   = OP_CODE_LENGTH'(4'b1011);
    localparam logic [OP_CODE_LENGTH-1:0] OP_JZ    = OP_CODE_LENGTH'(4'b1100);
    localparam logic [OP_CODE_LENGTH-1:0] OP_HALT  = OP_CODE_LENGTH'(4'b1111);

    state_t                    state_q, state_d;
    logic [OP_CODE_LENGTH-1:0] op_q;
    logic                      retire;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= FETCH;
            op_q          <= '0;
            retired_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q <= op_code;
            end
            if (retire) begin
                retired_count <= retired_count + COUNT_WIDTH'(1);
            end
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                // Decode acts on the live opcode; op_q only becomes valid afterwards.
                if (is_alu_operation) begin
                    state_d = EXECUTE;
                end else begin
                    case (op_code)
                        OP_LOADI:         state_d = WRITEBACK;
                        OP_LOAD, OP_STORE: state_d = MEMORY;
                        OP_HALT:          state_d = HALT;
                        default:          state_d = FETCH;
                    endcase
                end
            end
            EXECUTE:   state_d = WRITEBACK;
            MEMORY: begin
                if (mem_ready) state_d = (op_q == OP_STORE) ? FETCH : WRITEBACK;
            end
            WRITEBACK: state_d = FETCH;
            HALT:      state_d = HALT;
            default:   state_d = FETCH;
        endcase

        retire = ((state_d == FETCH) &&
                  (state_q == DECODE || state_q == MEMORY || state_q == WRITEBACK)) ||
                 ((state_d == HALT) && (state_q != HALT));
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_load       = 1'b0;
        pc_increment  = 1'b0;
        pc_load       = 1'b0;
        alu_enable    = 1'b0;
        reg_write     = 1'b0;
        reg_write_sel = 2'b00;
        halted        = 1'b0;
        // Outputs are forced quiet while reset is held, even mid-access.
        if (!reset) begin
            unique case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_load      = 1'b1;
                        pc_increment = 1'b1;
                    end
                end
                DECODE: begin
                    if (!is_alu_operation) begin
                        if (op_code == OP_JMP) pc_load = 1'b1;
                        if (op_code == OP_JZ)  pc_load = zero_flag;
                    end
                end
                EXECUTE: alu_enable = 1'b1;
                MEMORY: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_write    = (op_q == OP_STORE);
                end
                WRITEBACK: begin
                    reg_write = 1'b1;
                    if (op_q == OP_LOADI)     reg_write_sel = 2'b01;
                    else if (op_q == OP_LOAD) reg_write_sel = 2'b10;
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit; counter narrowed to 4 bits so the wrap test stays short.
module tb_control_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] op_code;
    logic       is_alu_operation;
    logic       zero_flag;
    logic       mem_ready;
    logic       mem_req, mem_write, mem_addr_sel;
    logic       ir_load, pc_increment, pc_load, alu_enable, reg_write;
    logic [1:0] reg_write_sel;
    logic       halted;
    logic [2:0] state;
    logic [3:0] retired_count;

    int checks = 0;
    int errors = 0;

    control_unit #(.OP_CODE_LENGTH(4), .COUNT_WIDTH(4)) dut (
        .clock(clock), .reset(reset), .op_code(op_code),
        .is_alu_operation(is_alu_operation), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
        .pc_increment(pc_increment), .pc_load(pc_load),
        .alu_enable(alu_enable), .reg_write(reg_write),
        .reg_write_sel(reg_write_sel), .halted(halted), .state(state),
        .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then settle past the edge before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [5:0] strobes();
        return {mem_req, ir_load, pc_increment, pc_load, alu_enable, reg_write};
    endfunction

    task automatic set_op(input logic [3:0] op, input logic alu);
        op_code          = op;
        is_alu_operation = alu;
    endtask

    initial begin
        reset = 1'b1;
        set_op(4'h0, 1'b0);
        zero_flag = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_state", state, 0);
        check("rst_count", retired_count, 0);
        reset = 1'b0;
        #1;
        check("first_mem_req", mem_req, 1);

        // ADD: states 0,1,2,4,0
        set_op(4'b0001, 1'b1);
        check("add_c1_state", state, 0);
        check("add_c1_irload", {ir_load, pc_increment}, 2'b11);
        tick();
        check("add_c2_state", state, 1);
        check("add_c2_strobes", strobes(), 0);
        tick();
        check("add_c3_state", state, 2);
        check("add_c3_alu", alu_enable, 1);
        tick();
        check("add_c4_state", state, 4);
        check("add_c4_rw", {reg_write, reg_write_sel}, 3'b100);
        check("add_c4_alu", alu_enable, 0);
        tick();
        check("add_done_state", state, 0);
        check("add_count", retired_count, 1);

        // LOAD with 3 wait cycles in MEMORY
        set_op(4'b1001, 1'b0);
        tick();
        check("ld_decode", state, 1);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            check($sformatf("ld_mem%0d_state", i), state, 3);
            check($sformatf("ld_mem%0d_bus", i), {mem_req, mem_addr_sel, mem_write}, 3'b110);
            tick();
        end
        check("ld_wb_state", state, 4);
        check("ld_wb_rw", {reg_write, reg_write_sel}, 3'b110);
        tick();
        check("ld_count", retired_count, 2);

        // JZ not taken, then taken
        set_op(4'b1100, 1'b0);
        zero_flag = 1'b0;
        tick();
        check("jz0_pc_load", pc_load, 0);
        tick();
        check("jz0_state", state, 0);
        check("jz0_count", retired_count, 3);
        zero_flag = 1'b1;
        tick();
        #1;
        check("jz1_pc_load", pc_load, 1);
        tick();
        check("jz1_state", state, 0);
        check("jz1_pc_load_off", pc_load, 0);
        check("jz1_count", retired_count, 4);
        zero_flag = 1'b0;

        // JMP
        set_op(4'b1011, 1'b0);
        tick();
        check("jmp_pc_load", pc_load, 1);
        tick();
        check("jmp_count", retired_count, 5);

        // LOADI: 3 cycles, writeback sel 01
        set_op(4'b1000, 1'b0);
        tick();
        tick();
        check("ldi_wb_state", state, 4);
        check("ldi_wb_rw", {reg_write, reg_write_sel}, 3'b101);
        tick();
        check("ldi_state", state, 0);
        check("ldi_count", retired_count, 6);

        // HALT: sticky with no strobes, counted on entry
        set_op(4'b1111, 1'b0);
        tick();
        tick();
        check("halt_count", retired_count, 7);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halt%0d_state", i), {halted, state}, 4'b1101);
            check($sformatf("halt%0d_strobes", i), {strobes(), mem_write}, 0);
            tick();
        end
        reset = 1'b1;
        tick();
        check("halt_rst", {halted, state, retired_count}, 0);
        reset = 1'b0;

        // STORE interrupted by reset during a memory wait
        set_op(4'b1010, 1'b0);
        tick();
        mem_ready = 1'b0;
        tick();
        check("st_mem", {state, mem_write}, 4'b0111);
        tick();
        reset = 1'b1;
        #1;
        check("st_rst_quiet", {mem_req, mem_write}, 0);
        tick();
        check("st_rst_state", state, 0);
        check("st_rst_out", {mem_write, reg_write}, 0);
        check("st_rst_count", retired_count, 0);
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("st_rst_fetch", mem_req, 1);

        // 16 NOPs wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) begin
            set_op((i % 2) ? 4'b1101 : 4'b0000, 1'b0);
            tick();
            tick();
            if (i == 14) check("nop_count15", retired_count, 15);
        end
        check("nop_wrap", retired_count, 0);
        check("nop_state", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter OP_CODE_LENGTH, default 4, opcode width matching the instruction decoder.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, width of the retired-instruction counter.
REQ-003 SHALL have port clock, input, 1, sole clock; all state changes on posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port op_code, input, OP_CODE_LENGTH, opcode from the instruction decoder.
REQ-006 SHALL have port is_alu_operation, input, 1, ALU-class flag from the decoder.
REQ-007 SHALL have port zero_flag, input, 1, ALU zero result flag.
REQ-008 SHALL have port mem_ready, input, 1, memory completes the current request this cycle.
REQ-009 SHALL have port mem_req, output, 1, memory access request.
REQ-010 SHALL have port mem_write, output, 1, 1 = store, 0 = read.
REQ-011 SHALL have port mem_addr_sel, output, 1, 0 = PC, 1 = memory_or_immediate operand.
REQ-012 SHALL have ports ir_load, pc_increment, pc_load, alu_enable and reg_write, each output, 1, single-cycle strobes.
REQ-013 SHALL have port reg_write_sel, output, 2, writeback source: 00 ALU, 01 immediate, 10 memory.
REQ-014 SHALL have ports halted, output, 1; state, output, 3; retired_count, output, COUNT_WIDTH.

Function
REQ-015 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5; state output = current encoding.
REQ-016 FETCH SHALL drive mem_req=1, mem_addr_sel=0 and mem_write=0, and SHALL hold until mem_ready=1; in that cycle ir_load=1, pc_increment=1, next=DECODE.
REQ-017 DECODE SHALL last exactly one cycle and SHALL latch op_code into an internal op register used by all later states of the instruction.
REQ-018 DECODE transitions SHALL be as follows.
- is_alu_operation=1 (ops 0001-0111) -> EXECUTE.
- 1000 LOADI -> WRITEBACK.
- 1001 LOAD or 1010 STORE -> MEMORY.
- 1011 JMP: pc_load=1, then FETCH.
- 1100 JZ: pc_load=zero_flag, then FETCH.
- 1111 HALT -> HALT.
- 0000 and 1101-1110 -> FETCH as a NOP.
REQ-019 EXECUTE SHALL drive alu_enable=1 for one cycle, then go to WRITEBACK.
REQ-020 MEMORY SHALL drive mem_req=1 and mem_addr_sel=1, with mem_write=1 only for STORE, and SHALL hold until mem_ready; then LOAD -> WRITEBACK and STORE -> FETCH.
REQ-021 WRITEBACK SHALL drive reg_write=1 for one cycle, with reg_write_sel 00 for ALU ops, 01 for LOADI and 10 for LOAD, then go to FETCH.
REQ-022 HALT SHALL drive halted=1 and all strobes 0, and SHALL remain there until reset.
REQ-023 mem_ready SHALL be ignored when mem_req=0.
REQ-024 retired_count SHALL increment by 1 on every transition into FETCH from DECODE, MEMORY or WRITEBACK, and on entry to HALT; it SHALL wrap from all-ones to 0.
REQ-025 Latency with mem_ready tied to 1 SHALL be: ALU op 4 cycles, LOADI 3, LOAD 4, STORE 3, JMP/JZ/NOP 2.
REQ-026 All outputs not explicitly asserted in a state SHALL be 0, and no strobe SHALL be asserted for more than one cycle per instruction.

Reset
REQ-027 While reset=1 at a posedge, the block SHALL go to FETCH and clear the op register and retired_count to 0.
REQ-028 During reset, all strobes, mem_req and halted SHALL be 0, and reset SHALL take priority over every transition, including mid-MEMORY wait and HALT.
REQ-029 The first mem_req SHALL assert in the first cycle after reset deasserts.

Verification
REQ-030 The bench SHALL check: mem_ready=1 and op 0001 (ADD) -> states 0,1,2,4,0; alu_enable in cycle 3; reg_write with sel 00 in cycle 4; retired_count=1.
REQ-031 The bench SHALL check: op 1001 (LOAD) with mem_ready low 3 cycles in MEMORY -> mem_req=1, mem_addr_sel=1 and mem_write=0 held 4 cycles; then WRITEBACK with sel 10.
REQ-032 The bench SHALL check: op 1100 (JZ) with zero_flag=0 -> pc_load stays 0; with zero_flag=1 -> pc_load=1 in DECODE; both cases -> FETCH, count +1 each.
REQ-033 The bench SHALL check: op 1111 -> halted=1 and state=5 for 20 cycles with no strobes; then reset=1 -> state=0, halted=0 and retired_count=0.
REQ-034 The bench SHALL check: reset asserted during a MEMORY wait for STORE -> next cycle state=0 with mem_write=0 and no reg_write.
REQ-035 The bench SHALL check: 2^COUNT_WIDTH NOPs -> retired_count wraps to 0.
